// File: rtl/wvb_rdout_pkg.sv
// Shared definitions for the waveform-buffer readout path.
//   DEF_ADDR_W    : default DPRAM read-port address width
//   DEF_DATA_W    : default DPRAM read-port data width
//   rdout_state_t : readout controller state encoding
package wvb_rdout_pkg;

    localparam int unsigned DEF_ADDR_W = 11;
    localparam int unsigned DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } rdout_state_t;

endpackage

// File: rtl/rdout_sync_fifo.sv
// Small synchronous FIFO used as the readout output buffer.
// The head entry is presented combinationally on rd_data (first-word
// fall-through) and reads as zero while the FIFO is empty.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   wr_en      : push wr_data (ignored when full)
//   rd_en      : pop the head entry (ignored when empty)
//   rd_data    : head entry
//   full/empty : occupancy flags
//   count      : number of stored entries, 0..DEPTH
module rdout_sync_fifo #(
    parameter int unsigned W     = 17,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dpram_rdout_ctrl.sv
// DPRAM readout controller: on dpram_run, reads dpram_len words (clamped to
// the DPRAM size) from DPRAM port B and streams them out with valid/ready.
//   clk, rst_n           : clock, asynchronous active-low reset
//   dpram_run, dpram_len : start pulse and word count from the writer
//   dpram_busy           : readout in progress
//   dpram_done           : one-cycle completion pulse
//   rd_addr, rd_data     : DPRAM port B (1-cycle read latency)
//   m_data, m_valid, m_last, m_ready : downstream stream
module dpram_rdout_ctrl
    import wvb_rdout_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dpram_run,
    input  logic [15:0]       dpram_len,
    output logic              dpram_busy,
    output logic              dpram_done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready
);

    // One extra bit so a full-size readout (2^ADDR_W words) is representable.
    localparam int unsigned       LEN_W   = ADDR_W + 1;
    localparam int unsigned       CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(1) << ADDR_W;

    rdout_state_t     state;
    rdout_state_t     state_next;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_clamped;
    logic [LEN_W-1:0] word_cnt;
    logic             load;
    logic             issue;
    logic             credit_ok;
    logic             is_last_addr;
    logic             pop;

    // v1: address on rd_addr this cycle; v2: its data on rd_data this cycle.
    logic             v1;
    logic             v1_last;
    logic             v2;
    logic             v2_last;

    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [DATA_W:0]  fifo_head;

    always_comb begin
        len_clamped = MAX_LEN;
        if (32'(dpram_len) <= 32'(MAX_LEN)) begin
            len_clamped = LEN_W'(dpram_len);
        end
    end

    // Reads still in the pipeline count against buffer space so the FIFO
    // can never overflow regardless of m_ready.
    assign credit_ok    = !fifo_full &&
                          ((32'(fifo_count) + 32'(v1) + 32'(v2)) < FIFO_DEPTH);
    assign is_last_addr = (word_cnt == (len_q - LEN_W'(1)));
    assign pop          = !fifo_empty && m_ready;

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        load       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dpram_run) begin
                    load       = 1'b1;
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                // A zero-length run still spends one busy cycle here before DONE.
                if (len_q == '0) begin
                    state_next = ST_DONE;
                end else if (credit_ok) begin
                    issue = 1'b1;
                    if (is_last_addr) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && fifo_head[DATA_W]) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (dpram_run) begin
                    load       = 1'b1;
                    state_next = ST_READ;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            word_cnt <= '0;
            rd_addr  <= '0;
            v1       <= 1'b0;
            v1_last  <= 1'b0;
            v2       <= 1'b0;
            v2_last  <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                len_q    <= len_clamped;
                word_cnt <= '0;
            end else if (issue) begin
                word_cnt <= word_cnt + LEN_W'(1);
            end
            if (issue) begin
                rd_addr <= word_cnt[ADDR_W-1:0];
            end
            v1      <= issue;
            v1_last <= issue && is_last_addr;
            v2      <= v1;
            v2_last <= v1_last;
        end
    end

    rdout_sync_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (v2),
        .wr_data ({v2_last, rd_data}),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign m_valid    = !fifo_empty;
    assign m_data     = fifo_head[DATA_W-1:0];
    assign m_last     = fifo_head[DATA_W];
    assign dpram_busy = (state == ST_READ) || (state == ST_DRAIN);
    assign dpram_done = (state == ST_DONE);

endmodule

// File: tb/tb_dpram_rdout_ctrl.sv
// Self-checking bench for dpram_rdout_ctrl. A behavioural DPRAM model feeds
// rd_data; each readout is compared against the expected word sequence
// mem[0..len-1] with m_last on the final word.
module tb_dpram_rdout_ctrl;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int MEM_N  = 2048;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              dpram_run = 1'b0;
    logic [15:0]       dpram_len = '0;
    logic              dpram_busy;
    logic              dpram_done;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready = 1'b0;

    logic [DATA_W-1:0] mem [MEM_N];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int n_xfer;
        int data_err;
        int n_last;
        int last_idx;
        int busy_cycles;
        int busy_c1;
        int first_valid;
        int valid_cycles;
        int last_xfer_cycle;
        int done_cycle;
        int done_after;
        int busy_after;
        int max_ahead;
        int stall_viol;
        int max_addr;
        int timeout;
    } stats_t;

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    dpram_rdout_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dpram_run  (dpram_run),
        .dpram_len  (dpram_len),
        .dpram_busy (dpram_busy),
        .dpram_done (dpram_done),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready)
    );

    // Drives one readout and gathers observations. Cycle 0 is the cycle in
    // which dpram_run is high; outputs are sampled on the falling edge.
    // mode: 0 ready always high, 1 toggling with a 15-cycle stall, 2 random.
    task automatic run_readout(input int len_in, input bit pulse, input int mode,
                               input int rerun_cyc, input int reset_at_word,
                               input int chain_len, output stats_t s);
        int eff;
        int c;
        int ahead;
        bit stalled;
        logic [DATA_W-1:0] prev_data;
        logic prev_last;
        s = '{default: 0};
        s.last_idx = -1;
        s.first_valid = -1;
        s.last_xfer_cycle = -1;
        s.done_cycle = -1;
        eff = (len_in > MEM_N) ? MEM_N : len_in;
        stalled = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        if (pulse) begin
            @(negedge clk);
            dpram_run = 1'b1;
            dpram_len = 16'(len_in);
        end
        c = 0;
        while (1) begin
            @(negedge clk);
            c++;
            dpram_run = (c == rerun_cyc);
            if (c == rerun_cyc) dpram_len = 16'd7;
            case (mode)
                0: m_ready = 1'b1;
                1: m_ready = (c >= 10 && c < 25) ? 1'b0 : ((c % 2) == 1);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (stalled && (!m_valid || m_data !== prev_data || m_last !== prev_last))
                s.stall_viol++;
            if (c == 1) s.busy_c1 = int'(dpram_busy);
            if (dpram_busy) s.busy_cycles++;
            if (m_valid) begin
                s.valid_cycles++;
                if (s.first_valid < 0) s.first_valid = c;
            end
            if (int'(rd_addr) > s.max_addr) s.max_addr = int'(rd_addr);
            if (s.first_valid >= 0) begin
                ahead = int'(rd_addr) + 1 - s.n_xfer;
                if (ahead > s.max_ahead) s.max_ahead = ahead;
            end
            if (m_valid && m_ready) begin
                if (s.n_xfer < eff) begin
                    if (m_data !== mem[s.n_xfer] || m_last !== (s.n_xfer == eff - 1))
                        s.data_err++;
                end else begin
                    s.data_err++;
                end
                if (m_last) begin
                    s.n_last++;
                    s.last_idx = s.n_xfer;
                end
                s.n_xfer++;
                s.last_xfer_cycle = c;
                if (s.n_xfer == reset_at_word) break;
            end
            stalled = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
            if (dpram_done) begin
                s.done_cycle = c;
                if (chain_len > 0) begin
                    dpram_run = 1'b1;
                    dpram_len = 16'(chain_len);
                end else begin
                    @(negedge clk);
                    s.done_after = int'(dpram_done);
                    s.busy_after = int'(dpram_busy);
                end
                break;
            end
            if (c > 6000) begin
                s.timeout = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (dpram_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", dpram_busy); end
        total++; if (dpram_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", dpram_done); end
        total++; if (m_valid !== 1'b0 || m_last !== 1'b0) begin bad++; $display("FAIL reset_valid_last: got %b%b want 00", m_valid, m_last); end
        total++; if (m_data !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", m_data); end
        total++; if (rd_addr !== '0) begin bad++; $display("FAIL reset_addr: got %0d want 0", rd_addr); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_len();
        stats_t s;
        run_readout(0, 1'b1, 0, -1, -1, 0, s);
        total++; if (s.done_cycle !== 2) begin bad++; $display("FAIL zero_done_cycle: got %0d want 2", s.done_cycle); end
        total++; if (s.busy_cycles !== 1) begin bad++; $display("FAIL zero_busy: got %0d want 1", s.busy_cycles); end
        total++; if (s.valid_cycles !== 0) begin bad++; $display("FAIL zero_valid: got %0d want 0", s.valid_cycles); end
        total++; if (s.max_addr !== 0) begin bad++; $display("FAIL zero_addr: got %0d want 0", s.max_addr); end
        total++; if (s.done_after !== 0) begin bad++; $display("FAIL zero_done_width: got %0d want 0", s.done_after); end
    endtask

    task automatic test_basic();
        stats_t s;
        for (int i = 0; i < 10; i++) mem[i] = 16'(i);
        run_readout(10, 1'b1, 0, -1, -1, 0, s);
        total++; if (s.n_xfer !== 10 || s.data_err !== 0) begin bad++; $display("FAIL basic_words: got %0d words %0d errs want 10 words 0 errs", s.n_xfer, s.data_err); end
        total++; if (s.n_last !== 1 || s.last_idx !== 9) begin bad++; $display("FAIL basic_last: got count %0d idx %0d want 1 idx 9", s.n_last, s.last_idx); end
        total++; if (s.first_valid !== 4) begin bad++; $display("FAIL basic_latency: got cycle %0d want 4", s.first_valid); end
        total++; if (s.busy_cycles !== 13) begin bad++; $display("FAIL basic_busy: got %0d want 13", s.busy_cycles); end
        total++; if (s.done_cycle !== 14 || s.done_cycle !== s.last_xfer_cycle + 1) begin bad++; $display("FAIL basic_done: got cycle %0d (last xfer %0d) want 14", s.done_cycle, s.last_xfer_cycle); end
        total++; if (s.done_after !== 0 || s.busy_after !== 0) begin bad++; $display("FAIL basic_after: got done %0d busy %0d want 0 0", s.done_after, s.busy_after); end
    endtask

    task automatic test_backpressure();
        stats_t s;
        int len;
        for (int i = 0; i < MEM_N; i++) mem[i] = 16'($urandom);
        run_readout(20, 1'b1, 1, -1, -1, 0, s);
        total++; if (s.n_xfer !== 20 || s.data_err !== 0) begin bad++; $display("FAIL bp_words: got %0d words %0d errs want 20 words 0 errs", s.n_xfer, s.data_err); end
        total++; if (s.stall_viol !== 0) begin bad++; $display("FAIL bp_stable: got %0d violations want 0", s.stall_viol); end
        total++; if (s.max_ahead > DEPTH) begin bad++; $display("FAIL bp_ahead: got %0d want <= %0d", s.max_ahead, DEPTH); end
        total++; if (s.last_idx !== 19 || s.timeout !== 0) begin bad++; $display("FAIL bp_last: got idx %0d timeout %0d want 19 0", s.last_idx, s.timeout); end
        for (int r = 0; r < 3; r++) begin
            len = $urandom_range(1, 40);
            run_readout(len, 1'b1, 2, -1, -1, 0, s);
            total++; if (s.n_xfer !== len || s.data_err !== 0 || s.stall_viol !== 0 || s.max_ahead > DEPTH)
                begin bad++; $display("FAIL rand_run%0d: got %0d words %0d errs %0d stall ahead %0d want %0d words clean", r, s.n_xfer, s.data_err, s.stall_viol, s.max_ahead, len); end
        end
    endtask

    task automatic test_clamp();
        stats_t s;
        run_readout(32'hFFFF, 1'b1, 0, -1, -1, 0, s);
        total++; if (s.n_xfer !== MEM_N || s.data_err !== 0) begin bad++; $display("FAIL clamp_words: got %0d words %0d errs want 2048 words 0 errs", s.n_xfer, s.data_err); end
        total++; if (s.last_idx !== MEM_N - 1 || s.n_last !== 1) begin bad++; $display("FAIL clamp_last: got idx %0d count %0d want 2047 1", s.last_idx, s.n_last); end
        total++; if (s.max_addr !== MEM_N - 1) begin bad++; $display("FAIL clamp_addr: got %0d want 2047", s.max_addr); end
    endtask

    task automatic test_reset_abort();
        stats_t s;
        int done_seen;
        run_readout(10, 1'b1, 0, 3, 5, 0, s);
        total++; if (s.n_xfer !== 5 || s.data_err !== 0 || s.done_cycle !== -1) begin bad++; $display("FAIL abort_prefix: got %0d words %0d errs done %0d want 5 0 -1", s.n_xfer, s.data_err, s.done_cycle); end
        rst_n = 1'b0;
        #1;
        total++; if (dpram_busy !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0) begin bad++; $display("FAIL abort_flags: got busy %b valid %b last %b want 000", dpram_busy, m_valid, m_last); end
        total++; if (m_data !== '0 || rd_addr !== '0) begin bad++; $display("FAIL abort_data_addr: got %h %0d want 0 0", m_data, rd_addr); end
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (dpram_done) done_seen++;
        end
        total++; if (done_seen !== 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", done_seen); end
        rst_n = 1'b1;
        @(negedge clk);
        run_readout(3, 1'b1, 0, -1, -1, 0, s);
        total++; if (s.n_xfer !== 3 || s.data_err !== 0 || s.last_idx !== 2) begin bad++; $display("FAIL abort_restart: got %0d words %0d errs last %0d want 3 0 2", s.n_xfer, s.data_err, s.last_idx); end
    endtask

    task automatic test_back_to_back();
        stats_t s1;
        stats_t s2;
        run_readout(4, 1'b1, 0, -1, -1, 5, s1);
        total++; if (s1.n_xfer !== 4 || s1.data_err !== 0 || s1.done_cycle < 0) begin bad++; $display("FAIL b2b_first: got %0d words %0d errs done %0d want 4 0 seen", s1.n_xfer, s1.data_err, s1.done_cycle); end
        run_readout(5, 1'b0, 0, -1, -1, 0, s2);
        total++; if (s2.busy_c1 !== 1) begin bad++; $display("FAIL b2b_busy: got %0d want 1", s2.busy_c1); end
        total++; if (s2.n_xfer !== 5 || s2.data_err !== 0 || s2.busy_cycles !== 8) begin bad++; $display("FAIL b2b_second: got %0d words %0d errs busy %0d want 5 0 8", s2.n_xfer, s2.data_err, s2.busy_cycles); end
    endtask

    initial begin
        for (int i = 0; i < MEM_N; i++) mem[i] = 16'($urandom);
        test_reset();
        test_zero_len();
        test_basic();
        test_backpressure();
        test_clamp();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
